// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - request/response front-end that issues one operation at a time to the dual-precision FPU
//
// Accepts a tagged request, drives registered opcode/operands/precision into
// the FPU, masks fpu_ready for SETTLE cycles after issue, then captures the
// result and flags (or a timeout) into a response register held until taken.
//
// Optional: define FPU_ISSUE_STATS_EN to add saturating stat_ops/stat_ovf/
// stat_unf/stat_tmo counters, bumped on each response handshake.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_sp_dp, req_op, req_a,
//   req_b, req_tag                request payload
//   fpu_sp_dp, fpu_opcode,
//   fpu_a_sp/b_sp, fpu_a_dp/b_dp  registered FPU inputs (last issued op)
//   fpu_result_sp/dp, fpu_overflow,
//   fpu_underflow, fpu_ready      FPU outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_overflow,
//   rsp_underflow, rsp_timeout,
//   rsp_tag                       response payload
//   stat_*                        (FPU_ISSUE_STATS_EN only) 16-bit counters

module fpu_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sp_dp,
    input  logic [1:0]       req_op,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fpu_sp_dp,
    output logic [1:0]       fpu_opcode,
    output logic [31:0]      fpu_a_sp,
    output logic [31:0]      fpu_b_sp,
    output logic [63:0]      fpu_a_dp,
    output logic [63:0]      fpu_b_dp,
    input  logic [31:0]      fpu_result_sp,
    input  logic [63:0]      fpu_result_dp,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_ovf,
    output logic [15:0]      stat_unf,
    output logic [15:0]      stat_tmo
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nx;
    logic [9:0]       cnt;
    logic             rdy_en;      // keeps req_ready low until the first edge after reset
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    logic [TAG_W-1:0] tag_q;

    logic accept;
    logic rsp_hs;
    logic ready_hit;
    logic timeout_hit;

    assign req_ready = rdy_en && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // fpu_ready takes priority over an expiring timeout in the same cycle
    assign ready_hit   = (state == S_WAIT) && fpu_ready;
    assign timeout_hit = (state == S_WAIT) && !fpu_ready && (cnt >= TIMEOUT_LAST);

    assign fpu_a_sp = a_q[31:0];
    assign fpu_b_sp = b_q[31:0];
    assign fpu_a_dp = a_q;
    assign fpu_b_dp = b_q;
    assign rsp_tag  = tag_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_SETTLE;
            S_SETTLE: if (cnt >= SETTLE_LAST) state_nx = S_WAIT;
            S_WAIT:   if (ready_hit || timeout_hit) state_nx = S_RESP;
            S_RESP:   if (rsp_hs) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == S_SETTLE || state == S_WAIT) && cnt != 10'h3FF) begin
            cnt <= cnt + 10'd1;
        end
    end

    // Issue registers: only a new acceptance changes what the FPU sees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_sp_dp  <= 1'b0;
            fpu_opcode <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
        end else if (accept) begin
            fpu_sp_dp  <= req_sp_dp;
            fpu_opcode <= req_op;
            a_q        <= req_a;
            b_q        <= req_b;
            tag_q      <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else if (ready_hit) begin
            rsp_result    <= fpu_sp_dp ? fpu_result_dp : {32'b0, fpu_result_sp};
            rsp_overflow  <= fpu_overflow;
            rsp_underflow <= fpu_underflow;
            rsp_timeout   <= 1'b0;
        end else if (timeout_hit) begin
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_timeout   <= 1'b1;
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
            stat_unf <= '0;
            stat_tmo <= '0;
        end else if (rsp_hs) begin
            if (stat_ops != 16'hFFFF)                  stat_ops <= stat_ops + 16'd1;
            if (rsp_overflow  && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
            if (rsp_underflow && stat_unf != 16'hFFFF) stat_unf <= stat_unf + 16'd1;
            if (rsp_timeout   && stat_tmo != 16'hFFFF) stat_tmo <= stat_tmo + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - randomized self-checking bench for fpu_issue_ctrl

module tb_fpu_issue_ctrl;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_sp_dp = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        fpu_sp_dp;
    logic [1:0]  fpu_opcode;
    logic [31:0] fpu_a_sp, fpu_b_sp;
    logic [63:0] fpu_a_dp, fpu_b_dp;
    logic [31:0] fpu_result_sp = '0;
    logic [63:0] fpu_result_dp = '0;
    logic        fpu_overflow = 1'b0;
    logic        fpu_underflow = 1'b0;
    logic        fpu_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result;
    logic        rsp_overflow, rsp_underflow, rsp_timeout;
    logic [3:0]  rsp_tag;
`ifdef FPU_ISSUE_STATS_EN
    logic [15:0] stat_ops, stat_ovf, stat_unf, stat_tmo;
`endif

    fpu_issue_ctrl #(.TAG_W(4), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sp_dp(req_sp_dp),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_sp_dp(fpu_sp_dp), .fpu_opcode(fpu_opcode),
        .fpu_a_sp(fpu_a_sp), .fpu_b_sp(fpu_b_sp), .fpu_a_dp(fpu_a_dp), .fpu_b_dp(fpu_b_dp),
        .fpu_result_sp(fpu_result_sp), .fpu_result_dp(fpu_result_dp),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_ready(fpu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .rsp_timeout(rsp_timeout), .rsp_tag(rsp_tag)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .stat_ops(stat_ops), .stat_ovf(stat_ovf), .stat_unf(stat_unf), .stat_tmo(stat_tmo)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // fixed FPU result values for directed cases
    logic        fix_en = 1'b0;
    logic [31:0] fix_sp = '0;
    logic [63:0] fix_dp = '0;
    logic        fix_ovf = 1'b0;
    logic        fix_unf = 1'b0;

    // reference statistics
    int m_ops = 0, m_ovf = 0, m_unf = 0, m_tmo = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FPU ready pattern relative to acceptance edge 0: mode 0 = high from cycle p on, mode 1 = pulse at p
    function automatic bit rdy_at(input int mode, input int p, input int k);
        return (mode == 0) ? (k >= p) : (k == p);
    endfunction

    // Drives one FPU cycle's outputs; ready per pattern, results random or fixed
    task automatic drive_fpu(input bit rdy);
        fpu_ready     = rdy;
        fpu_result_sp = fix_en ? fix_sp : $urandom;
        fpu_result_dp = fix_en ? fix_dp : {$urandom, $urandom};
        fpu_overflow  = fix_en ? fix_ovf : 1'($urandom);
        fpu_underflow = fix_en ? fix_unf : 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle
    task automatic do_op(input logic sp, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] tag,
                         input int mode, input int p, input int hold);
        int          cap;
        bit          tmo;
        logic [63:0] e_res;
        logic        e_ovf, e_unf;
        cap = TIMEOUT;
        tmo = 1'b1;
        for (int k = SETTLE + 1; k <= TIMEOUT; k++) begin
            if (rdy_at(mode, p, k)) begin
                cap = k;
                tmo = 1'b0;
                break;
            end
        end
        e_res = '0; e_ovf = 1'b0; e_unf = 1'b0;

        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_sp_dp = sp; req_op = op; req_a = a; req_b = b; req_tag = tag;
        drive_fpu(rdy_at(mode, p, 0));
        @(negedge clk);
        // keep offering a different request; it must not be taken while busy
        req_tag = tag + 4'd1; req_a = ~a;
        chk("fpu_sp_dp", fpu_sp_dp, sp);
        chk("fpu_opcode", fpu_opcode, op);
        chk("fpu_a_dp", fpu_a_dp, a);
        chk("fpu_b_sp", fpu_b_sp, b[31:0]);
        for (int k = 1; k <= cap; k++) begin
            drive_fpu(rdy_at(mode, p, k));
            if (k == cap && !tmo) begin
                e_res = sp ? fpu_result_dp : {32'b0, fpu_result_sp};
                e_ovf = fpu_overflow;
                e_unf = fpu_underflow;
            end
            @(negedge clk);
            if (k == 1) chk("req_ready_busy", req_ready, 1'b0);
            if (k < cap && !rsp_valid) continue;
            chk("rsp_valid_cycle", k, cap);
            if (rsp_valid) break;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                drive_fpu(1'($urandom));
                @(negedge clk);
            end
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_result", rsp_result, e_res);
            chk("rsp_flags", {rsp_overflow, rsp_underflow, rsp_timeout}, {e_ovf, e_unf, tmo});
            chk("rsp_tag", rsp_tag, tag);
            chk("req_ready_resp", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        m_ops++; m_ovf += int'(e_ovf); m_unf += int'(e_unf); m_tmo += int'(tmo);
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("req_ready_after", req_ready, 1'b1);
        chk("fpu_a_hold", fpu_a_dp, a);
        chk("fpu_opcode_hold", fpu_opcode, op);
    endtask

    task automatic chk_stats(input string tag);
`ifdef FPU_ISSUE_STATS_EN
        chk({tag, "_ops"}, stat_ops, m_ops);
        chk({tag, "_ovf"}, stat_ovf, m_ovf);
        chk({tag, "_unf"}, stat_unf, m_unf);
        chk({tag, "_tmo"}, stat_tmo, m_tmo);
`else
        chk({tag, "_idle"}, req_ready, 1'b1);
`endif
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp", {rsp_result, rsp_overflow, rsp_underflow, rsp_timeout, rsp_tag}, '0);
        chk("rst_fpu", {fpu_a_dp, fpu_b_dp, fpu_opcode, fpu_sp_dp}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1'b1);

        // directed SP add, ready 3 cycles after issue
        fix_en = 1'b1; fix_sp = 32'h4040_0000; fix_dp = '0; fix_ovf = 1'b0; fix_unf = 1'b0;
        do_op(1'b0, 2'b00, 64'h3F80_0000, 64'h4000_0000, 4'h5, 0, 3, 0);
        // ready held from before issue: capture on first WAIT cycle
        do_op(1'b0, 2'b01, 64'h1234, 64'h5678, 4'h6, 0, 0, 0);
        // DP mul, FPU never ready: timeout after 64 cycles
        do_op(1'b1, 2'b10, {$urandom, $urandom}, {$urandom, $urandom}, 4'h9, 1, -1, 0);
        // response back-pressure for 10 cycles
        fix_en = 1'b0;
        do_op(1'b1, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 4'hA, 0, 7, 10);
        // ready and timeout coincide, overflow set
        fix_en = 1'b1; fix_dp = 64'hDEAD_BEEF_0000_0001; fix_ovf = 1'b1;
        do_op(1'b1, 2'b10, 64'h1, 64'h2, 4'hB, 1, TIMEOUT, 0);
        // ready pulse inside the settle window is ignored
        fix_en = 1'b0;
        do_op(1'b0, 2'b00, 64'h7, 64'h8, 4'hC, 1, SETTLE, 0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            int md;
            md = $urandom_range(0, 1);
            do_op(1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom), md, md ? $urandom_range(0, 66) : $urandom_range(0, 70),
                  $urandom_range(0, 3));
        end
        chk_stats("stats");

        // reset during WAIT
        req_valid = 1'b1; req_sp_dp = 1'b1; req_op = 2'b10; req_a = 64'hFF; req_b = 64'hEE; req_tag = 4'h3;
        fpu_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_ops = 0; m_ovf = 0; m_unf = 0; m_tmo = 0;
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_fpu", {fpu_a_dp, fpu_b_dp, fpu_opcode, fpu_sp_dp}, '0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
`ifdef FPU_ISSUE_STATS_EN
        chk_stats("rst_stats");
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        do_op(1'b0, 2'b01, 64'hAB, 64'hCD, 4'hE, 0, 5, 1);
        chk_stats("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
